// File: rtl/uart_cmd_ctrl.sv
// UART command frame parser: HDR CMD DH DL CHK -> one register command.
// Bad frames (parity, checksum, inter-byte timeout) are counted and flagged.
module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER  = 8'hAA,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DH,
        S_DL,
        S_CHK,
        S_ISSUE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       dh_q, dh_d;
    logic [7:0]       dl_q, dl_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             cmd_write_q, cmd_write_d;
    logic [6:0]       cmd_addr_q, cmd_addr_d;
    logic [15:0]      cmd_data_q, cmd_data_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             busy_q, busy_d;
    logic             abort;
    logic [1:0]       abort_code;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        abort       = 1'b0;
        abort_code  = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_ready && !rx_error && rx_data == HEADER) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_CMD, S_DH, S_DL, S_CHK: begin
                // A byte in the terminal-count cycle beats the timeout.
                if (rx_ready) begin
                    cnt_d = '0;
                    if (rx_error) begin
                        abort      = 1'b1;
                        abort_code = 2'd1;
                    end else if (state_q == S_CMD) begin
                        op_d    = rx_data;
                        state_d = S_DH;
                    end else if (state_q == S_DH) begin
                        dh_d    = rx_data;
                        state_d = S_DL;
                    end else if (state_q == S_DL) begin
                        dl_d    = rx_data;
                        state_d = S_CHK;
                    end else if (rx_data == (op_q ^ dh_q ^ dl_q)) begin
                        state_d     = S_ISSUE;
                        cmd_valid_d = 1'b1;
                        cmd_write_d = op_q[7];
                        cmd_addr_d  = op_q[6:0];
                        cmd_data_d  = {dh_q, dl_q};
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'd2;
                    end
                end else if (cnt_q == TERM) begin
                    abort      = 1'b1;
                    abort_code = 2'd3;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = abort_code;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a byte-stream frame model predicts
// commands and aborts; a monitor pops and compares on every DUT event.
module tb_uart_cmd_ctrl;

    localparam int TMO = 40;
    localparam logic [7:0] HDR = 8'hAA;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic        busy;

    uart_cmd_ctrl #(
        .HEADER (HDR),
        .TIMEOUT(TMO),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_error (rx_error),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .frame_err(frame_err),
        .err_code (err_code),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    logic [23:0] exp_cmd[$];
    logic [9:0]  exp_err[$];

    int         m_pos = 0;
    int         m_cnt = 0;
    logic [7:0] m_buf[5];
    int         last_edge = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_err(input logic [1:0] code);
        if (m_cnt < 255) m_cnt++;
        exp_err.push_back({code, 8'(m_cnt)});
    endtask

    // Frame rules applied to one received byte; gap = cycles since last byte.
    task automatic model_byte(input logic [7:0] b, input bit e,
                              input int gap, output bit iss);
        iss = 1'b0;
        if (m_pos > 0 && gap > TMO) begin
            push_err(2'd3);
            m_pos = 0;
        end
        if (m_pos == 0) begin
            if (!e && b == HDR) m_pos = 1;
        end else if (e) begin
            push_err(2'd1);
            m_pos = 0;
        end else if (m_pos < 4) begin
            m_buf[m_pos] = b;
            m_pos++;
        end else begin
            if (b == (m_buf[1] ^ m_buf[2] ^ m_buf[3])) begin
                exp_cmd.push_back({m_buf[1], m_buf[2], m_buf[3]});
                iss = 1'b1;
            end else begin
                push_err(2'd2);
            end
            m_pos = 0;
        end
    endtask

    task automatic idle_wait(input int n);
        if (m_pos > 0 && cyc + n - last_edge >= TMO) begin
            push_err(2'd3);
            m_pos = 0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e,
                             input int idle, input int hold);
        bit iss;
        model_byte(b, e, cyc + idle + 1 - last_edge, iss);
        repeat (idle) @(negedge clk);
        if (iss) cmd_ready = (hold == 0);
        rx_ready  = 1'b1;
        rx_data   = b;
        rx_error  = e;
        last_edge = cyc + 1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        if (iss) begin
            for (int i = 0; i < hold; i++) begin
                rx_ready = ($urandom_range(0, 2) == 0);
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
            rx_ready  = 1'b0;
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] k,
                              input int idle_max, input int hold);
        send_byte(HDR, 1'b0, $urandom_range(0, idle_max), 0);
        send_byte(c, 1'b0, $urandom_range(0, idle_max), 0);
        send_byte(h, 1'b0, $urandom_range(0, idle_max), 0);
        send_byte(l, 1'b0, $urandom_range(0, idle_max), 0);
        send_byte(k, 1'b0, $urandom_range(0, idle_max), hold);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_cmd_write"}, 32'(cmd_write), 0);
        chk({tag, "_cmd_addr"},  32'(cmd_addr), 0);
        chk({tag, "_cmd_data"},  32'(cmd_data), 0);
        chk({tag, "_frame_err"}, 32'(frame_err), 0);
        chk({tag, "_err_code"},  32'(err_code), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
        chk({tag, "_busy"},      32'(busy), 0);
    endtask

    // Monitor: outputs sampled 1 time unit after the edge; inputs seen then
    // are the ones the DUT sampled at that edge.
    logic        vld_prev = 1'b0;
    logic [23:0] cur = '0;
    logic [23:0] xc;
    logic [9:0]  xe;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                if (exp_err.size() == 0) begin
                    chk("unexpected_frame_err", 32'(err_code), 0);
                end else begin
                    xe = exp_err.pop_front();
                    chk("err_code", 32'(err_code), 32'(xe[9:8]));
                    chk("err_count", 32'(err_count), 32'(xe[7:0]));
                end
            end
            if (vld_prev && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_cmd", 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    xc = exp_cmd.pop_front();
                    chk("cmd_fields", 32'(cur), 32'(xc));
                end
                chk("cmd_valid_drop", 32'(cmd_valid), 0);
            end else if (vld_prev && cmd_valid) begin
                chk("cmd_stable", 32'({cmd_write, cmd_addr, cmd_data}),
                    32'(cur));
            end
            if (cmd_valid && !vld_prev) begin
                chk("cmd_latency", 32'(rx_ready), 1);
                cur = {cmd_write, cmd_addr, cmd_data};
            end
            vld_prev = cmd_valid;
        end
    end

    logic [7:0] c, h, l, k;
    logic [7:0] fb[5];
    int         kind;
    int         p;

    initial begin
        reset_n   = 1'b0;
        rx_ready  = 1'b0;
        rx_data   = '0;
        rx_error  = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Write frame, ready already high
        send_byte(HDR, 1'b0, 0, 0);
        chk("busy_in_frame", 32'(busy), 1);
        send_byte(8'h85, 1'b0, 0, 0);
        send_byte(8'h12, 1'b0, 0, 0);
        send_byte(8'h34, 1'b0, 0, 0);
        send_byte(8'hA3, 1'b0, 0, 0);
        idle_wait(2);
        chk("busy_after_cmd", 32'(busy), 0);

        // Bad checksum then a good frame
        send_frame(8'h05, 8'h00, 8'h10, 8'h00, 0, 0);
        send_frame(8'h01, 8'hAB, 8'hCD, 8'h01 ^ 8'hAB ^ 8'hCD, 1, 1);

        // Timeout, then both sides of the terminal count
        send_byte(HDR, 1'b0, 0, 0);
        send_byte(8'h85, 1'b0, 0, 0);
        idle_wait(TMO + 3);
        chk("busy_after_timeout", 32'(busy), 0);
        chk("code_after_timeout", 32'(err_code), 3);
        send_byte(HDR, 1'b0, 0, 0);
        send_byte(8'h85, 1'b0, 0, 0);
        send_byte(8'h12, 1'b0, TMO - 1, 0);
        send_byte(8'h34, 1'b0, 0, 0);
        send_byte(8'hA3, 1'b0, 0, 0);
        send_byte(HDR, 1'b0, 0, 0);
        send_byte(8'h85, 1'b0, TMO, 0);
        idle_wait(3);

        // Parity error in frame; junk in idle is ignored
        send_byte(HDR, 1'b0, 0, 0);
        send_byte(8'h85, 1'b1, 0, 0);
        send_byte(8'h55, 1'b0, 0, 0);
        send_byte(8'hFF, 1'b0, 0, 0);
        send_byte(HDR, 1'b1, 0, 0);
        idle_wait(2);
        chk("count_after_junk", 32'(err_count), 32'(m_cnt));
        chk("busy_after_junk", 32'(busy), 0);

        // Back-pressure for 20 cycles with extra bytes arriving
        send_frame(8'h42, 8'h5A, 8'hA5, 8'h42 ^ 8'h5A ^ 8'hA5, 0, 20);

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 4);
            c = 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            k = c ^ h ^ l;
            fb[0] = HDR;
            fb[1] = c;
            fb[2] = h;
            fb[3] = l;
            fb[4] = k;
            case (kind)
                0: send_frame(c, h, l, k, 2, $urandom_range(0, 4));
                1: send_frame(c, h, l, k ^ (8'(1) << $urandom_range(0, 7)),
                              2, 0);
                2: begin
                    p = $urandom_range(1, 4);
                    for (int j = 0; j < 5; j++)
                        send_byte(fb[j], (j == p), $urandom_range(0, 2), 0);
                end
                3: begin
                    for (int j = 0; j < 5; j++)
                        send_byte(fb[j], 1'b0,
                                  ($urandom_range(0, 2) == 0) ?
                                  TMO - 2 + $urandom_range(0, 2) : 0,
                                  $urandom_range(0, 2));
                end
                default: begin
                    repeat ($urandom_range(1, 3))
                        send_byte(8'($urandom), 1'($urandom_range(0, 1)),
                                  0, 0);
                end
            endcase
        end
        idle_wait(TMO + 2);

        // Saturation of the abort counter
        for (int n = 0; n < 260; n++) begin
            send_byte(HDR, 1'b0, 0, 0);
            send_byte(8'($urandom), 1'b1, 0, 0);
        end
        idle_wait(2);
        chk("err_count_sat", 32'(err_count), 32'h0000_00FF);

        // Asynchronous reset mid-frame
        send_byte(HDR, 1'b0, 0, 0);
        send_byte(8'h11, 1'b0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midframe_reset");
        m_pos = 0;
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame(8'h7F, 8'h00, 8'h01, 8'h7F ^ 8'h00 ^ 8'h01, 0, 2);

        idle_wait(TMO + 5);
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 0);
        chk("err_queue_empty", 32'(exp_err.size()), 0);
        chk("final_err_count", 32'(err_count), 32'(m_cnt));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
